// File: rtl/spi_master_pkg.sv
// Shared types and constants for the parametrised SPI master.
package spi_master_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEAD  = 2'd1,
      SHIFT = 2'd2,
      TRAIL = 2'd3
   } state_e;

   // SPI modes encoded as {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period tick generator: down-counter reloaded with the divider on restart
// or on reaching zero; tick_o marks the last clk cycle of each half-period.
module spi_clk_tick #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q - DIV_W'(1);
      if (restart_i || (cnt_q == '0)) begin
         cnt_d = div_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with CPOL/CPHA modes, SCLK divider,
// configurable bit order and one-hot active-low chip selects.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; sclk parked at latched cpol, cs_n all high
// LEAD  | chip select asserted, one half-period of CS setup
// SHIFT | 2*DATA_W half-periods, sclk toggles at the end of each one
// TRAIL | one half-period of CS hold, then done pulse and release
module spi_master_param
   import spi_master_pkg::*;
#(
   parameter int  DATA_W    = 8,
   parameter int  NUM_CS    = 4,
   parameter int  DIV_W     = 8,
   parameter bit  MSB_FIRST = 1'b1,
   localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [DIV_W-1:0]  clk_div,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] dout,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int              HP_W    = $clog2(2 * DATA_W);
   localparam int              FIRST   = MSB_FIRST ? DATA_W - 1 : 0;
   localparam int              NEXT    = MSB_FIRST ? DATA_W - 2 : 1;
   localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_W - 1);

   state_e            state_q, state_d;
   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              done_q, done_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [HP_W-1:0]   hp_q, hp_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;

   logic [DATA_W-1:0] tx_shift, rx_shift;
   logic [NUM_CS-1:0] cs_dec;
   logic [DIV_W-1:0]  tick_div;
   logic              tick, tick_restart;
   logic              lead_edge, last_hp;

   // Even half-periods end in a leading edge, odd ones in a trailing edge.
   assign lead_edge = ~hp_q[0];
   assign last_hp   = (hp_q == HP_LAST);

   assign tx_shift = MSB_FIRST ? {tx_q[DATA_W-2:0], 1'b0} : {1'b0, tx_q[DATA_W-1:1]};
   assign rx_shift = MSB_FIRST ? {rx_q[DATA_W-2:0], miso} : {miso, rx_q[DATA_W-1:1]};

   // Out-of-range selects decode to no asserted chip select.
   always_comb begin
      cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (cs_sel == CS_W'(i)) begin
            cs_dec[i] = 1'b0;
         end
      end
   end

   // Counter tracks the live divider while idle so the accept edge loads it.
   assign tick_restart = (state_q == IDLE) || (state_d != state_q);
   assign tick_div     = (state_q == IDLE) ? clk_div : div_q;

   spi_clk_tick #(
      .DIV_W (DIV_W)
   ) u_tick (
      .clk       (clk),
      .rst       (rst),
      .restart_i (tick_restart),
      .div_i     (tick_div),
      .tick_o    (tick)
   );

   always_comb begin
      state_d = state_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;
      div_d   = div_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      hp_d    = hp_q;
      cs_n_d  = cs_n_q;

      unique case (state_q)
         IDLE: begin
            sclk_d = cpol_q;
            if (start) begin
               state_d = LEAD;
               cpol_d  = cpol;
               cpha_d  = cpha;
               div_d   = clk_div;
               tx_d    = din;
               rx_d    = '0;
               hp_d    = '0;
               sclk_d  = cpol;
               cs_n_d  = cs_dec;
               mosi_d  = cpha ? 1'b0 : din[FIRST];
            end
         end

         LEAD: begin
            if (tick) begin
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               hp_d   = hp_q + HP_W'(1);
               if (lead_edge) begin
                  if (cpha_q) begin
                     mosi_d = tx_q[FIRST];
                     tx_d   = tx_shift;
                  end else begin
                     rx_d = rx_shift;
                  end
               end else begin
                  if (cpha_q) begin
                     rx_d = rx_shift;
                  end else if (!last_hp) begin
                     mosi_d = tx_q[NEXT];
                     tx_d   = tx_shift;
                  end
               end
               if (last_hp) begin
                  state_d = TRAIL;
                  hp_d    = '0;
               end
            end
         end

         TRAIL: begin
            if (tick) begin
               state_d = IDLE;
               cs_n_d  = '1;
               mosi_d  = 1'b0;
               dout_d  = rx_q;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
         div_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         hp_q    <= '0;
         cs_n_q  <= '1;
      end else begin
         state_q <= state_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         div_q   <= div_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         hp_q    <= hp_d;
         cs_n_q  <= cs_n_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign dout = dout_q;
   assign sclk = sclk_q;
   assign mosi = mosi_q;
   assign cs_n = cs_n_q;

endmodule
